// File: rtl/sdcard_blkq.sv
// sdcard_blkq: SD-card block buffer and command queue.
// The host sees a window onto one 512-byte block buffer plus a small
// control register set (STATUS, SELECT, READ/WRITE enqueue, BUFMASK).
// Block commands are queued FIFO. The PHY pops them one at a time and then
// streams bytes into (reads) or out of (writes) the referenced buffer.
// Buffers referenced by a queued or active command are locked against
// host access until the PHY finishes with them.
//
// Handshake: phy_cmd_vld_o/phy_cmd_rdy_i follow strict valid/ready rules.
// A command transfers on any rising clk_i edge where both are high.
// phy_cmd_vld_o does not depend on phy_cmd_rdy_i. phy_cmd_o and
// phy_cmdaddr_o stay stable while phy_cmd_vld_o is high and not yet
// accepted. A host flush is the only thing that may withdraw a pending
// command.
module sdcard_blkq #(
  parameter int  ARCHBITSZ = 32,
  parameter int  BUFCNT    = 4,
  parameter int  PHYBLKSZ  = 512,
  localparam int BPW       = ARCHBITSZ / 8,
  localparam int ADDRBITSZ = ARCHBITSZ - $clog2(BPW)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [1:0]           pi1_op_i,
  input  logic [ADDRBITSZ-1:0] pi1_addr_i,
  input  logic [ARCHBITSZ-1:0] pi1_data_i,
  input  logic [BPW-1:0]       pi1_sel_i,
  output logic [ARCHBITSZ-1:0] pi1_data_o,
  output logic                 pi1_rdy_o,
  output logic [ADDRBITSZ-1:0] pi1_mapsz_o,
  output logic                 intrqst_o,
  input  logic                 intrdy_i,
  output logic                 phy_rst_o,
  output logic                 phy_cmd_vld_o,
  input  logic                 phy_cmd_rdy_i,
  output logic                 phy_cmd_o,
  output logic [ADDRBITSZ-1:0] phy_cmdaddr_o,
  input  logic                 phy_rx_push_i,
  input  logic [7:0]           phy_rx_data_i,
  input  logic                 phy_tx_pop_i,
  output logic [7:0]           phy_tx_data_o,
  input  logic                 phy_done_i,
  input  logic [ADDRBITSZ-1:0] phy_blkcnt_i,
  input  logic                 phy_err_i
);

  localparam int MAPSZ  = PHYBLKSZ / BPW;
  localparam int BUFIDX = $clog2(BUFCNT);
  localparam int CNTW   = BUFIDX + 1;
  localparam int PTRW   = $clog2(PHYBLKSZ);
  localparam int WIDXW  = $clog2(MAPSZ);
  localparam int BSELW  = $clog2(BPW);
  localparam int MEMSZ  = BUFCNT * PHYBLKSZ;

  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(BUFCNT);
  localparam logic [PTRW-1:0] PTR_LAST = PTRW'(PHYBLKSZ - 1);

  // Transfer engine: idle (may accept a queued command) or busy with one block.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } xfer_state_t;

  xfer_state_t state_q, state_d;

  // Command queue: circular buffer indexed by head (oldest) and tail (next free).
  logic [CNTW-1:0]      count_q, count_d;
  logic [BUFIDX-1:0]    head_q, head_d;
  logic [BUFIDX-1:0]    tail_q, tail_d;
  logic                 q_wr_q   [BUFCNT];
  logic [ADDRBITSZ-1:0] q_addr_q [BUFCNT];
  logic [BUFIDX-1:0]    q_buf_q  [BUFCNT];

  // Active transfer context and host window.
  logic [BUFIDX-1:0]    act_buf_q, act_buf_d;
  logic [PTRW-1:0]      ptr_q, ptr_d;
  logic [BUFIDX-1:0]    hostbuf_q, hostbuf_d;
  logic [ARCHBITSZ-1:0] rdata_q, rdata_d;

  // Interrupt and edge-detect state.
  logic irq_q, irq_d;
  logic err_q;
  logic intrdy_q;
  logic phy_rst_q;

  // Block buffers stored as bytes so the PHY byte stream and host words share one array.
  logic [7:0] mem_q [MEMSZ];

  // Host request decode.
  logic                 op_rw;
  logic                 is_ctl;
  logic                 is_mem;
  logic                 mem_wr;
  logic                 ctl_status;
  logic                 ctl_select;
  logic                 ctl_enq;
  logic                 q_full;
  logic                 do_enq;
  logic                 do_flush;
  logic                 do_pop;
  logic                 cmd_vld;
  logic                 xfer_active;
  logic                 done_evt;
  logic                 host_blocked;
  logic [WIDXW-1:0]     host_word;
  logic [BUFCNT-1:0]    busy_mask;
  logic [BUFIDX-1:0]    slot_off;
  logic [ARCHBITSZ-1:0] host_rdata;
  logic [ARCHBITSZ-1:0] ctl_rdata;
  logic [1:0]           status;

  assign op_rw      = (pi1_op_i == 2'b11);
  assign is_ctl     = op_rw && (pi1_addr_i < ADDRBITSZ'(5));
  assign is_mem     = (pi1_op_i != 2'b00) && !is_ctl;
  assign mem_wr     = is_mem && pi1_op_i[0];
  assign ctl_status = is_ctl && (pi1_addr_i[2:0] == 3'd0);
  assign ctl_select = is_ctl && (pi1_addr_i[2:0] == 3'd1);
  assign ctl_enq    = is_ctl && (pi1_addr_i[2:1] == 2'b01);

  // A full queue rejects a new command even if the PHY pops in the same cycle.
  assign q_full     = (count_q == CNT_FULL);
  assign do_enq     = ctl_enq && !q_full;
  assign do_flush   = ctl_status && (pi1_data_i != '0);

  assign xfer_active = (state_q == ST_XFER);
  assign cmd_vld     = (count_q != '0) && !xfer_active;
  assign do_pop      = cmd_vld && phy_cmd_rdy_i;
  assign done_evt    = xfer_active && phy_done_i;

  assign host_word    = pi1_addr_i[WIDXW-1:0];
  assign host_blocked = busy_mask[hostbuf_q];

  // Mark every buffer referenced by a live queue slot or by the active transfer.
  always_comb begin
    busy_mask = '0;
    slot_off  = '0;
    for (int i = 0; i < BUFCNT; i++) begin
      slot_off = BUFIDX'(i) - head_q;
      if (CNTW'(slot_off) < count_q) begin
        busy_mask[q_buf_q[i]] = 1'b1;
      end
    end
    if (xfer_active) begin
      busy_mask[act_buf_q] = 1'b1;
    end
  end

  // Assemble the addressed host word, little-endian, from the byte array.
  always_comb begin
    host_rdata = '0;
    for (int b = 0; b < BPW; b++) begin
      host_rdata[8*b +: 8] = mem_q[{hostbuf_q, host_word, BSELW'(b)}];
    end
  end

  // Status code: error wins over busy, busy over ready.
  always_comb begin
    status = 2'd1;
    if (phy_err_i) begin
      status = 2'd3;
    end else if ((count_q != '0) || xfer_active) begin
      status = 2'd2;
    end
  end

  // Control register read values.
  always_comb begin
    ctl_rdata = '0;
    case (pi1_addr_i[2:0])
      3'd0:       ctl_rdata = ARCHBITSZ'({count_q, status});
      3'd1:       ctl_rdata = ARCHBITSZ'(PHYBLKSZ);
      3'd2, 3'd3: ctl_rdata = q_full ? '0 : ARCHBITSZ'(phy_blkcnt_i);
      3'd4:       ctl_rdata = ARCHBITSZ'(busy_mask);
      default:    ctl_rdata = '0;
    endcase
  end

  // Transfer FSM next state plus queue, pointer and host-side next values. Flush overrides all.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    head_d    = head_q;
    tail_d    = tail_q;
    act_buf_d = act_buf_q;
    ptr_d     = ptr_q;
    hostbuf_d = hostbuf_q;
    rdata_d   = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (do_pop) begin
          state_d   = ST_XFER;
          act_buf_d = q_buf_q[head_q];
          ptr_d     = '0;
        end
      end
      ST_XFER: begin
        // The pointer sticks on the last byte so overruns never leave the buffer.
        if ((phy_rx_push_i || phy_tx_pop_i) && (ptr_q != PTR_LAST)) begin
          ptr_d = ptr_q + 1'b1;
        end
        if (phy_done_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_pop) begin
      head_d = head_q + 1'b1;
    end
    if (do_enq) begin
      tail_d = tail_q + 1'b1;
    end
    case ({do_enq, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (ctl_select) begin
      hostbuf_d = pi1_data_i[BUFIDX-1:0];
    end
    if (pi1_op_i[1]) begin
      rdata_d = is_ctl ? ctl_rdata : (host_blocked ? '0 : host_rdata);
    end

    if (do_flush) begin
      state_d = ST_IDLE;
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
      ptr_d   = '0;
    end
  end

  // Interrupt: set on block completion or error onset, cleared when the acknowledge falls.
  always_comb begin
    if (irq_q) begin
      irq_d = !(intrdy_q && !intrdy_i);
    end else begin
      irq_d = done_evt || (phy_err_i && !err_q);
    end
  end

  // State registers with synchronous active-low reset. Edge detectors track inputs through reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      act_buf_q <= '0;
      ptr_q     <= '0;
      hostbuf_q <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
      err_q     <= phy_err_i;
      intrdy_q  <= intrdy_i;
      phy_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      act_buf_q <= act_buf_d;
      ptr_q     <= ptr_d;
      hostbuf_q <= hostbuf_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
      err_q     <= phy_err_i;
      intrdy_q  <= intrdy_i;
      phy_rst_q <= do_flush;
    end
  end

  // Queue slot payload. Slots only matter while counted, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (do_enq) begin
      q_wr_q[tail_q]   <= (pi1_addr_i[1:0] == 2'b11);
      q_addr_q[tail_q] <= pi1_data_i[ADDRBITSZ-1:0];
      q_buf_q[tail_q]  <= hostbuf_q;
    end
  end

  // Buffer writes. Host and PHY never hit the same buffer because a busy buffer blocks the host.
  always_ff @(posedge clk_i) begin
    if (mem_wr && !host_blocked) begin
      for (int b = 0; b < BPW; b++) begin
        if (pi1_sel_i[b]) begin
          mem_q[{hostbuf_q, host_word, BSELW'(b)}] <= pi1_data_i[8*b +: 8];
        end
      end
    end
    if (xfer_active && phy_rx_push_i) begin
      mem_q[{act_buf_q, ptr_q}] <= phy_rx_data_i;
    end
  end

  assign pi1_data_o    = rdata_q;
  assign pi1_rdy_o     = 1'b1;
  assign pi1_mapsz_o   = ADDRBITSZ'(MAPSZ);
  assign intrqst_o     = irq_q;
  assign phy_rst_o     = phy_rst_q;
  assign phy_cmd_vld_o = cmd_vld;
  assign phy_cmd_o     = q_wr_q[head_q];
  assign phy_cmdaddr_o = q_addr_q[head_q];
  assign phy_tx_data_o = xfer_active ? mem_q[{act_buf_q, ptr_q}] : 8'h00;

endmodule

// File: tb/tb_sdcard_blkq.sv
// Directed testbench for sdcard_blkq with default parameters (32-bit host, 4 buffers).
`timescale 1ns/1ps
module tb_sdcard_blkq;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  pi1_op_i;
  logic [29:0] pi1_addr_i;
  logic [31:0] pi1_data_i;
  logic [3:0]  pi1_sel_i;
  logic [31:0] pi1_data_o;
  logic        pi1_rdy_o;
  logic [29:0] pi1_mapsz_o;
  logic        intrqst_o;
  logic        intrdy_i;
  logic        phy_rst_o;
  logic        phy_cmd_vld_o;
  logic        phy_cmd_rdy_i;
  logic        phy_cmd_o;
  logic [29:0] phy_cmdaddr_o;
  logic        phy_rx_push_i;
  logic [7:0]  phy_rx_data_i;
  logic        phy_tx_pop_i;
  logic [7:0]  phy_tx_data_o;
  logic        phy_done_i;
  logic [29:0] phy_blkcnt_i;
  logic        phy_err_i;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] rd;

  sdcard_blkq dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .pi1_op_i      (pi1_op_i),
    .pi1_addr_i    (pi1_addr_i),
    .pi1_data_i    (pi1_data_i),
    .pi1_sel_i     (pi1_sel_i),
    .pi1_data_o    (pi1_data_o),
    .pi1_rdy_o     (pi1_rdy_o),
    .pi1_mapsz_o   (pi1_mapsz_o),
    .intrqst_o     (intrqst_o),
    .intrdy_i      (intrdy_i),
    .phy_rst_o     (phy_rst_o),
    .phy_cmd_vld_o (phy_cmd_vld_o),
    .phy_cmd_rdy_i (phy_cmd_rdy_i),
    .phy_cmd_o     (phy_cmd_o),
    .phy_cmdaddr_o (phy_cmdaddr_o),
    .phy_rx_push_i (phy_rx_push_i),
    .phy_rx_data_i (phy_rx_data_i),
    .phy_tx_pop_i  (phy_tx_pop_i),
    .phy_tx_data_o (phy_tx_data_o),
    .phy_done_i    (phy_done_i),
    .phy_blkcnt_i  (phy_blkcnt_i),
    .phy_err_i     (phy_err_i)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  // Driver tasks: inputs change 1ns after the rising edge, outputs are read there too.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic host_op(input logic [1:0] op, input logic [29:0] addr,
                         input logic [31:0] data, input logic [3:0] sel,
                         output logic [31:0] rdata);
    pi1_op_i   = op;
    pi1_addr_i = addr;
    pi1_data_i = data;
    pi1_sel_i  = sel;
    tick();
    rdata      = pi1_data_o;
    pi1_op_i   = 2'b00;
    pi1_data_i = '0;
    pi1_sel_i  = '0;
  endtask

  task automatic accept();
    phy_cmd_rdy_i = 1'b1;
    tick();
    phy_cmd_rdy_i = 1'b0;
  endtask

  task automatic done_pulse();
    phy_done_i = 1'b1;
    tick();
    phy_done_i = 1'b0;
  endtask

  task automatic irq_ack();
    intrdy_i = 1'b1;
    tick();
    intrdy_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    tick();
    tick();
    checks++; if (phy_rst_o !== 1'b1) begin failures++; $display("FAIL rst_phy_rst got=%b exp=1", phy_rst_o); end
    checks++; if (phy_cmd_vld_o !== 1'b0) begin failures++; $display("FAIL rst_vld got=%b exp=0", phy_cmd_vld_o); end
    checks++; if (intrqst_o !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b exp=0", intrqst_o); end
    checks++; if (pi1_data_o !== 32'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", pi1_data_o); end
    checks++; if (pi1_rdy_o !== 1'b1) begin failures++; $display("FAIL rst_rdy got=%b exp=1", pi1_rdy_o); end
    checks++; if (pi1_mapsz_o !== 30'd128) begin failures++; $display("FAIL rst_mapsz got=%0d exp=128", pi1_mapsz_o); end
    rst_i = 1'b1;
    tick();
    checks++; if (phy_rst_o !== 1'b0) begin failures++; $display("FAIL rel_phy_rst got=%b exp=0", phy_rst_o); end
  endtask

  task automatic test_write_cmd();
    host_op(2'b01, 30'd0, 32'h11223344, 4'hF, rd);
    host_op(2'b11, 30'd3, 32'h80, 4'h0, rd);
    checks++; if (rd !== 32'h1234) begin failures++; $display("FAIL wc_ret got=%h exp=1234", rd); end
    checks++; if (phy_cmd_vld_o !== 1'b1) begin failures++; $display("FAIL wc_vld got=%b exp=1", phy_cmd_vld_o); end
    checks++; if (phy_cmd_o !== 1'b1) begin failures++; $display("FAIL wc_cmd got=%b exp=1", phy_cmd_o); end
    checks++; if (phy_cmdaddr_o !== 30'h80) begin failures++; $display("FAIL wc_addr got=%h exp=80", phy_cmdaddr_o); end
    accept();
    checks++; if (phy_cmd_vld_o !== 1'b0) begin failures++; $display("FAIL wc_vld_active got=%b exp=0", phy_cmd_vld_o); end
    checks++; if (phy_tx_data_o !== 8'h44) begin failures++; $display("FAIL wc_tx0 got=%h exp=44", phy_tx_data_o); end
    phy_tx_pop_i = 1'b1;
    tick();
    checks++; if (phy_tx_data_o !== 8'h33) begin failures++; $display("FAIL wc_tx1 got=%h exp=33", phy_tx_data_o); end
    tick();
    checks++; if (phy_tx_data_o !== 8'h22) begin failures++; $display("FAIL wc_tx2 got=%h exp=22", phy_tx_data_o); end
    tick();
    checks++; if (phy_tx_data_o !== 8'h11) begin failures++; $display("FAIL wc_tx3 got=%h exp=11", phy_tx_data_o); end
    phy_tx_pop_i = 1'b0;
    done_pulse();
    checks++; if (intrqst_o !== 1'b1) begin failures++; $display("FAIL wc_irq got=%b exp=1", intrqst_o); end
    host_op(2'b11, 30'd4, 32'h0, 4'h0, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL wc_mask got=%h exp=0", rd); end
    irq_ack();
    checks++; if (intrqst_o !== 1'b0) begin failures++; $display("FAIL wc_irq_ack got=%b exp=0", intrqst_o); end
  endtask

  task automatic test_read_block();
    host_op(2'b11, 30'd1, 32'd2, 4'h0, rd);
    checks++; if (rd !== 32'd512) begin failures++; $display("FAIL rb_select got=%0d exp=512", rd); end
    host_op(2'b11, 30'd2, 32'd7, 4'h0, rd);
    checks++; if (rd !== 32'h1234) begin failures++; $display("FAIL rb_ret got=%h exp=1234", rd); end
    checks++; if (phy_cmd_o !== 1'b0) begin failures++; $display("FAIL rb_cmd got=%b exp=0", phy_cmd_o); end
    checks++; if (phy_cmdaddr_o !== 30'd7) begin failures++; $display("FAIL rb_addr got=%h exp=7", phy_cmdaddr_o); end
    host_op(2'b11, 30'd4, 32'h0, 4'h0, rd);
    checks++; if (rd !== 32'h4) begin failures++; $display("FAIL rb_mask_q got=%h exp=4", rd); end
    accept();
    host_op(2'b11, 30'd4, 32'h0, 4'h0, rd);
    checks++; if (rd !== 32'h4) begin failures++; $display("FAIL rb_mask_act got=%h exp=4", rd); end
    for (int i = 0; i < 512; i++) begin
      phy_rx_push_i = 1'b1;
      phy_rx_data_i = 8'(i);
      tick();
    end
    // One extra byte lands on the saturated last position.
    phy_rx_data_i = 8'hAA;
    tick();
    phy_rx_push_i = 1'b0;
    done_pulse();
    checks++; if (intrqst_o !== 1'b1) begin failures++; $display("FAIL rb_irq got=%b exp=1", intrqst_o); end
    host_op(2'b11, 30'd4, 32'h0, 4'h0, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rb_mask_done got=%h exp=0", rd); end
    host_op(2'b10, 30'd1, 32'h0, 4'h0, rd);
    checks++; if (rd !== 32'h07060504) begin failures++; $display("FAIL rb_word1 got=%h exp=07060504", rd); end
    host_op(2'b10, 30'd127, 32'h0, 4'h0, rd);
    checks++; if (rd !== 32'hAAFEFDFC) begin failures++; $display("FAIL rb_word127 got=%h exp=aafefdfc", rd); end
    irq_ack();
    checks++; if (intrqst_o !== 1'b0) begin failures++; $display("FAIL rb_irq_ack got=%b exp=0", intrqst_o); end
  endtask

  task automatic test_queue_full();
    phy_blkcnt_i = 30'h55;
    for (int k = 0; k < 4; k++) begin
      host_op(2'b11, 30'd2, 32'(10 + k), 4'h0, rd);
      checks++; if (rd !== 32'h55) begin failures++; $display("FAIL qf_enq%0d got=%h exp=55", k, rd); end
    end
    host_op(2'b11, 30'd2, 32'd14, 4'h0, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL qf_drop got=%h exp=0", rd); end
    host_op(2'b11, 30'd0, 32'h0, 4'h0, rd);
    checks++; if (rd !== 32'h12) begin failures++; $display("FAIL qf_status got=%h exp=12", rd); end
    checks++; if (phy_cmdaddr_o !== 30'd10) begin failures++; $display("FAIL qf_head got=%0d exp=10", phy_cmdaddr_o); end
    // Full queue rejects even while the PHY pops in the same cycle.
    phy_cmd_rdy_i = 1'b1;
    host_op(2'b11, 30'd2, 32'd20, 4'h0, rd);
    phy_cmd_rdy_i = 1'b0;
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL qf_drop_pop got=%h exp=0", rd); end
    host_op(2'b11, 30'd0, 32'h0, 4'h0, rd);
    checks++; if (rd !== 32'h0E) begin failures++; $display("FAIL qf_status3 got=%h exp=0e", rd); end
    done_pulse();
    for (int k = 1; k < 4; k++) begin
      checks++; if (phy_cmdaddr_o !== 30'(10 + k)) begin failures++; $display("FAIL qf_fifo%0d got=%0d exp=%0d", k, phy_cmdaddr_o, 10 + k); end
      accept();
      done_pulse();
    end
    host_op(2'b11, 30'd0, 32'h0, 4'h0, rd);
    checks++; if (rd !== 32'h01) begin failures++; $display("FAIL qf_status_empty got=%h exp=01", rd); end
    // Simultaneous enqueue and pop keeps the count.
    host_op(2'b11, 30'd2, 32'd30, 4'h0, rd);
    phy_cmd_rdy_i = 1'b1;
    host_op(2'b11, 30'd2, 32'd31, 4'h0, rd);
    phy_cmd_rdy_i = 1'b0;
    checks++; if (rd !== 32'h55) begin failures++; $display("FAIL qf_enq_pop got=%h exp=55", rd); end
    host_op(2'b11, 30'd0, 32'h0, 4'h0, rd);
    checks++; if (rd !== 32'h06) begin failures++; $display("FAIL qf_status_ep got=%h exp=06", rd); end
    done_pulse();
    checks++; if (phy_cmd_vld_o !== 1'b1) begin failures++; $display("FAIL qf_vld_next got=%b exp=1", phy_cmd_vld_o); end
    checks++; if (phy_cmdaddr_o !== 30'd31) begin failures++; $display("FAIL qf_head31 got=%0d exp=31", phy_cmdaddr_o); end
    accept();
    done_pulse();
    host_op(2'b11, 30'd0, 32'h0, 4'h0, rd);
    checks++; if (rd !== 32'h01) begin failures++; $display("FAIL qf_status_end got=%h exp=01", rd); end
    irq_ack();
  endtask

  task automatic test_blocked();
    host_op(2'b11, 30'd1, 32'd1, 4'h0, rd);
    host_op(2'b01, 30'd5, 32'hCAFEBABE, 4'hF, rd);
    host_op(2'b01, 30'd6, 32'h11223344, 4'hF, rd);
    host_op(2'b01, 30'd6, 32'hAABBCCDD, 4'b0101, rd);
    host_op(2'b10, 30'd6, 32'h0, 4'h0, rd);
    checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL bl_lanes got=%h exp=11bb33dd", rd); end
    host_op(2'b11, 30'd2, 32'h40, 4'h0, rd);
    host_op(2'b11, 30'd4, 32'h0, 4'h0, rd);
    checks++; if (rd !== 32'h2) begin failures++; $display("FAIL bl_mask got=%h exp=2", rd); end
    host_op(2'b10, 30'd5, 32'h0, 4'h0, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL bl_read_locked got=%h exp=0", rd); end
    host_op(2'b01, 30'd5, 32'h12345678, 4'hF, rd);
    accept();
    done_pulse();
    host_op(2'b10, 30'd5, 32'h0, 4'h0, rd);
    checks++; if (rd !== 32'hCAFEBABE) begin failures++; $display("FAIL bl_write_dropped got=%h exp=cafebabe", rd); end
    host_op(2'b11, 30'd5, 32'h0BADF00D, 4'hF, rd);
    checks++; if (rd !== 32'hCAFEBABE) begin failures++; $display("FAIL bl_rw_old got=%h exp=cafebabe", rd); end
    host_op(2'b10, 30'd133, 32'h0, 4'h0, rd);
    checks++; if (rd !== 32'h0BADF00D) begin failures++; $display("FAIL bl_wrap got=%h exp=0badf00d", rd); end
    irq_ack();
  endtask

  task automatic test_flush();
    host_op(2'b11, 30'd1, 32'd3, 4'h0, rd);
    host_op(2'b11, 30'd2, 32'd9, 4'h0, rd);
    accept();
    host_op(2'b11, 30'd2, 32'd10, 4'h0, rd);
    host_op(2'b11, 30'd0, 32'd1, 4'h0, rd);
    checks++; if (rd !== 32'h06) begin failures++; $display("FAIL fl_status_pre got=%h exp=06", rd); end
    checks++; if (phy_rst_o !== 1'b1) begin failures++; $display("FAIL fl_phy_rst got=%b exp=1", phy_rst_o); end
    host_op(2'b11, 30'd0, 32'd0, 4'h0, rd);
    checks++; if (rd !== 32'h01) begin failures++; $display("FAIL fl_status_post got=%h exp=01", rd); end
    checks++; if (phy_rst_o !== 1'b0) begin failures++; $display("FAIL fl_phy_rst_end got=%b exp=0", phy_rst_o); end
    host_op(2'b11, 30'd4, 32'h0, 4'h0, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL fl_mask got=%h exp=0", rd); end
    checks++; if (phy_cmd_vld_o !== 1'b0) begin failures++; $display("FAIL fl_vld got=%b exp=0", phy_cmd_vld_o); end
    done_pulse();
    checks++; if (intrqst_o !== 1'b0) begin failures++; $display("FAIL fl_irq got=%b exp=0", intrqst_o); end
  endtask

  task automatic test_reset_mid();
    host_op(2'b11, 30'd2, 32'd5, 4'h0, rd);
    accept();
    phy_rx_push_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      phy_rx_data_i = 8'(i);
      tick();
    end
    phy_rx_push_i = 1'b0;
    rst_i = 1'b0;
    phy_err_i = 1'b1;
    tick();
    checks++; if (phy_rst_o !== 1'b1) begin failures++; $display("FAIL rm_phy_rst got=%b exp=1", phy_rst_o); end
    checks++; if (phy_cmd_vld_o !== 1'b0) begin failures++; $display("FAIL rm_vld got=%b exp=0", phy_cmd_vld_o); end
    checks++; if (intrqst_o !== 1'b0) begin failures++; $display("FAIL rm_irq got=%b exp=0", intrqst_o); end
    checks++; if (pi1_data_o !== 32'h0) begin failures++; $display("FAIL rm_data got=%h exp=0", pi1_data_o); end
    tick();
    rst_i = 1'b1;
    tick();
    tick();
    checks++; if (intrqst_o !== 1'b0) begin failures++; $display("FAIL rm_irq_rel got=%b exp=0", intrqst_o); end
    checks++; if (phy_rst_o !== 1'b0) begin failures++; $display("FAIL rm_phy_rst_rel got=%b exp=0", phy_rst_o); end
    host_op(2'b11, 30'd0, 32'h0, 4'h0, rd);
    checks++; if (rd !== 32'h03) begin failures++; $display("FAIL rm_status got=%h exp=03", rd); end
    host_op(2'b11, 30'd3, 32'd1, 4'h0, rd);
    host_op(2'b11, 30'd4, 32'h0, 4'h0, rd);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL rm_hostbuf got=%h exp=1", rd); end
    host_op(2'b11, 30'd0, 32'd1, 4'h0, rd);
    checks++; if (rd !== 32'h07) begin failures++; $display("FAIL rm_status_err got=%h exp=07", rd); end
    done_pulse();
    checks++; if (intrqst_o !== 1'b0) begin failures++; $display("FAIL rm_done_irq got=%b exp=0", intrqst_o); end
    phy_err_i = 1'b0;
    tick();
  endtask

  task automatic test_err_irq();
    phy_err_i = 1'b1;
    tick();
    checks++; if (intrqst_o !== 1'b1) begin failures++; $display("FAIL ei_rise got=%b exp=1", intrqst_o); end
    irq_ack();
    checks++; if (intrqst_o !== 1'b0) begin failures++; $display("FAIL ei_ack got=%b exp=0", intrqst_o); end
    tick();
    checks++; if (intrqst_o !== 1'b0) begin failures++; $display("FAIL ei_level got=%b exp=0", intrqst_o); end
    phy_err_i = 1'b0;
    tick();
  endtask

  initial begin
    rst_i         = 1'b0;
    pi1_op_i      = 2'b00;
    pi1_addr_i    = '0;
    pi1_data_i    = '0;
    pi1_sel_i     = '0;
    intrdy_i      = 1'b0;
    phy_cmd_rdy_i = 1'b0;
    phy_rx_push_i = 1'b0;
    phy_rx_data_i = '0;
    phy_tx_pop_i  = 1'b0;
    phy_done_i    = 1'b0;
    phy_blkcnt_i  = 30'h1234;
    phy_err_i     = 1'b0;

    test_reset();
    test_write_cmd();
    test_read_block();
    test_queue_full();
    test_blocked();
    test_flush();
    test_reset_mid();
    test_err_irq();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
